// File: rtl/dds_meter_pkg.sv
// Shared types and field layout for the DDS waveform meter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dds_meter_pkg;

   // Meter sequencing: discard the partial first cycle, measure, then hold a result
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_REPORT  = 2'd2
   } meter_state_e;

   // Measurement word layout
   localparam int MEAS_W   = 48;
   localparam int OVF_BIT  = 47;
   localparam int ZERO_MSB = 46;
   localparam int ZERO_LSB = 40;
   localparam int PER_MSB  = 39;
   localparam int PER_LSB  = 16;
   localparam int MAX_MSB  = 15;
   localparam int MAX_LSB  = 8;
   localparam int MIN_MSB  = 7;
   localparam int MIN_LSB  = 0;

   localparam int PER_W = PER_MSB - PER_LSB + 1;
   localparam int AMP_W = MAX_MSB - MAX_LSB + 1;

endpackage

// File: rtl/dds_amp_track.sv
// Running min/max of DDS samples over one waveform period; only built with DDS_WAVE_METER_AMP_EN.
// Latency: min_o/max_o reflect a sample one cycle after it is presented.
// Backpressure: none; the parent decides which cycles update or restart the tracker.
`ifdef DDS_WAVE_METER_AMP_EN
module dds_amp_track #(
   parameter int DATA_W      = 8,
   parameter int SIGNED_DATA = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] sample_i,
   input  logic              update_i,
   input  logic              restart_i,
   output logic [DATA_W-1:0] min_o,
   output logic [DATA_W-1:0] max_o
);

   logic [DATA_W-1:0] min_q, min_d;
   logic [DATA_W-1:0] max_q, max_d;
   logic              below, above;

   // Compare against the running extremes; restart seeds both from the new sample
   always_comb begin
      below = 1'b0;
      above = 1'b0;
      if (SIGNED_DATA != 0) begin
         below = $signed(sample_i) < $signed(min_q);
         above = $signed(sample_i) > $signed(max_q);
      end else begin
         below = sample_i < min_q;
         above = sample_i > max_q;
      end
      min_d = min_q;
      max_d = max_q;
      if (restart_i) begin
         min_d = sample_i;
         max_d = sample_i;
      end else if (update_i) begin
         if (below) min_d = sample_i;
         if (above) max_d = sample_i;
      end
   end

   // Extreme registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         min_q <= '0;
         max_q <= '0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
   end

   assign min_o = min_q;
   assign max_o = max_q;

endmodule
`endif

// File: rtl/dds_wave_meter.sv
// Measures DDS waveform period (beats between phase wraps) and, with DDS_WAVE_METER_AMP_EN, sample min/max.
// Latency: a closing wrap accepted at cycle N raises m_axis_meas_tvalid at N+1.
// Backpressure: both input treadys drop while a result waits on m_axis_meas_tready; no beat is dropped.
module dds_wave_meter
   import dds_meter_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int PHASE_W     = 16,
   parameter int CNT_W       = 24,
   parameter int SIGNED_DATA = 1
) (
   input  logic               aclk,
   input  logic               reset,
   input  logic [DATA_W-1:0]  s_axis_data_tdata,
   input  logic               s_axis_data_tvalid,
   output logic               s_axis_data_tready,
   input  logic [PHASE_W-1:0] s_axis_phase_tdata,
   input  logic               s_axis_phase_tvalid,
   output logic               s_axis_phase_tready,
   output logic [MEAS_W-1:0]  m_axis_meas_tdata,
   output logic               m_axis_meas_tvalid,
   input  logic               m_axis_meas_tready
);

   meter_state_e       state_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [PHASE_W-1:0] prev_q;
   logic               prev_vld_q;
   logic               tvalid_q;
   logic [MEAS_W-1:0]  tdata_q, meas_d;
   logic               s_rdy, beat, wrap;
   logic [AMP_W-1:0]   max_fld, min_fld;

   // Inputs are taken together as one beat; ready never looks at valid
   assign s_rdy = ~reset & (state_q != ST_REPORT);
   assign beat  = s_rdy & s_axis_data_tvalid & s_axis_phase_tvalid;
   assign wrap  = beat & prev_vld_q & (s_axis_phase_tdata < prev_q);

`ifdef DDS_WAVE_METER_AMP_EN
   logic [DATA_W-1:0] amp_min, amp_max;

   dds_amp_track #(
      .DATA_W      (DATA_W),
      .SIGNED_DATA (SIGNED_DATA)
   ) u_amp (
      .clk_i     (aclk),
      .rst_i     (reset),
      .sample_i  (s_axis_data_tdata),
      .update_i  (beat & (state_q == ST_MEASURE)),
      .restart_i (wrap),
      .min_o     (amp_min),
      .max_o     (amp_max)
   );

   assign max_fld = AMP_W'(amp_max);
   assign min_fld = AMP_W'(amp_min);
`else
   logic unused_amp;
   assign unused_amp = ^{s_axis_data_tdata, SIGNED_DATA != 0};
   assign max_fld    = '0;
   assign min_fld    = '0;
`endif

   // Saturating beat counter; pinning at all-ones flags the period as overflowed
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      ovf_d = ovf_q;
      if (&cnt_q) begin
         cnt_d = cnt_q;
         ovf_d = 1'b1;
      end
   end

   // Assemble the result word from the period that the current wrap closes
   always_comb begin
      meas_d = '0;
      meas_d[OVF_BIT]         = ovf_q;
      meas_d[PER_MSB:PER_LSB] = PER_W'(cnt_q);
      meas_d[MAX_MSB:MAX_LSB] = max_fld;
      meas_d[MIN_MSB:MIN_LSB] = min_fld;
   end

   // Sequencer: wrap detection, period counting and the held output register
   always_ff @(posedge aclk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
         tvalid_q   <= 1'b0;
         tdata_q    <= '0;
      end else begin
         if (beat) begin
            prev_q     <= s_axis_phase_tdata;
            prev_vld_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (wrap) begin
                  cnt_q   <= CNT_W'(1);
                  ovf_q   <= 1'b0;
                  state_q <= ST_MEASURE;
               end
            end
            ST_MEASURE: begin
               if (wrap) begin
                  tdata_q  <= meas_d;
                  tvalid_q <= 1'b1;
                  cnt_q    <= CNT_W'(1);
                  ovf_q    <= 1'b0;
                  state_q  <= ST_REPORT;
               end else if (beat) begin
                  cnt_q <= cnt_d;
                  ovf_q <= ovf_d;
               end
            end
            ST_REPORT: begin
               if (m_axis_meas_tready) begin
                  tvalid_q <= 1'b0;
                  state_q  <= ST_MEASURE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign s_axis_data_tready  = s_rdy;
   assign s_axis_phase_tready = s_rdy;
   assign m_axis_meas_tvalid  = tvalid_q & ~reset;
   assign m_axis_meas_tdata   = reset ? '0 : tdata_q;

endmodule
